sync_queue: RTL and testbench
=============================

SYNC_QUEUE -- requirements
Module: sync_queue

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, width of one queue entry in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 SHALL use one clock; reset is synchronous and active-low. Ports: clk, rst_n.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 data_i  input  DATA_SIZE  writer data.
REQ-007 valide  input  1  writer offers data_i this cycle.
REQ-008 ready_o  output  1  queue can accept a write this cycle.
REQ-009 flush  input  1  discard all contents (pipeline flush).
REQ-010 data_o  output  DATA_SIZE  head entry, visible to reader.
REQ-011 valid_o  output  1  data_o holds a valid entry.
REQ-012 ok  input  1  reader consumes head this cycle.
REQ-013 count_o  output  clog2(DEPTH)+1  current number of stored entries.

Function
REQ-014 SHALL define push = valide AND ready_o, and pop = valid_o AND ok.
REQ-015 SHALL drive ready_o = (count_o != DEPTH) and valid_o = (count_o != 0), both combinational from registered state.
REQ-016 SHALL write data_i at the write pointer on push; the entry SHALL be visible on data_o one cycle later if the queue was empty (first-word fall-through, no same-cycle bypass).
REQ-017 SHALL drive data_o from the entry at the read pointer when valid_o=1, and 0 (bubble) when valid_o=0.
REQ-018 SHALL advance the write pointer on push and the read pointer on pop, each wrapping from DEPTH-1 to 0.
REQ-019 SHALL update count_o +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-020 SHALL deliver entries to the reader in exact write order, with no loss or duplication.
REQ-021 When full, SHALL refuse a write even if a pop occurs in the same cycle (ready_o=0 holds).
REQ-022 When empty, SHALL ignore ok with no state change.
REQ-023 SHALL give flush priority over push and pop: on flush=1 both pointers and count_o become 0 next cycle; any same-cycle write is discarded and any same-cycle pop is irrelevant.
REQ-024 SHALL never underflow or overflow count_o for any input sequence.

Reset
REQ-025 On rising clk with rst_n=0, SHALL set both pointers and count_o to 0; valid_o=0, ready_o=1, data_o=0 from that edge onward.
REQ-026 Reset SHALL override flush, push and pop; contents held before a mid-operation reset SHALL be lost.
REQ-027 SHALL NOT need to clear the storage array on reset; no stale entry may become visible.

Structure
REQ-028 SHALL add no shared-package entries; pointer and count widths SHALL be local parameters derived from DEPTH.
REQ-029 SHALL be a single module with no sub-modules; storage is a flip-flop array of DEPTH x DATA_SIZE.

Verification
REQ-030 Reset, then write 0x11, 0x22, 0x33 on consecutive cycles with ok=0 -> count_o=3, data_o=0x11, valid_o=1.
REQ-031 From empty, write 0xA5 with ok=1 held -> valid_o=1 with data_o=0xA5 one cycle after the write, then empty one cycle later.
REQ-032 DEPTH=4: write 4 entries -> ready_o=0. Then valide=1, ok=1 for one cycle -> one pop and no push, count_o=3.
REQ-033 Stream 10 writes 0x1..0xA with ok toggling every cycle -> reader gets 0x1..0xA in order across pointer wrap, count_o never above 4.
REQ-034 With 3 entries stored, flush=1 together with valide=1 (data 0x77) -> next cycle count_o=0, valid_o=0, data_o=0; 0x77 never appears.
REQ-035 With 2 entries stored, rst_n=0 for one cycle -> count_o=0, ready_o=1, valid_o=0. A later write of 0x5 is read out first.

Source files
------------

// File: rtl/sync_queue.sv
// Single-clock FIFO with first-word fall-through, synchronous active-low reset
// and a flush that empties the queue in one cycle.
module sync_queue #(
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_SIZE-1:0]   data_i,
   input  logic                   valide,
   output logic                   ready_o,
   input  logic                   flush,
   output logic [DATA_SIZE-1:0]   data_o,
   output logic                   valid_o,
   input  logic                   ok,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 push;
   logic                 pop;

   assign ready_o = (count != FULL);
   assign valid_o = (count != '0);
   assign push    = valide && ready_o;
   assign pop     = valid_o && ok;
   assign count_o = count;
   assign data_o  = valid_o ? mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; data_o is masked by valid_o, so
   // stale entries can never reach the reader.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: tb/tb_sync_queue.sv
// Randomised scoreboard bench for sync_queue: the driver queues expected words,
// an independent negedge monitor checks status and retires words on each pop.
module tb_sync_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data_i;
   logic          valide;
   logic          ready_o;
   logic          flush;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ok;
   logic [2:0]    count_o;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   logic          pending_push = 1'b0;
   logic          mon_en = 1'b0;

   sync_queue #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (data_i),
      .valide  (valide),
      .ready_o (ready_o),
      .flush   (flush),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ok      (ok),
      .count_o (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: room exists unless the stored backlog equals DEPTH; a write
   // accepted this cycle becomes an expected reader word.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic o,
                       input logic f, input logic r);
      rst_n  = r;
      valide = v;
      data_i = d;
      ok     = o;
      flush  = f;
      pending_push = r && !f && v && (exp_q.size() != DEPTH);
      if (pending_push) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         int stored;
         stored = exp_q.size() - (pending_push ? 1 : 0);
         check("count", 32'(count_o), 32'(stored));
         check("valid", 32'(valid_o), 32'(stored != 0));
         check("ready", 32'(ready_o), 32'(stored != DEPTH));
         if (stored == 0) check("bubble", data_o, '0);
         if (!rst_n || flush) begin
            exp_q.delete();
         end else if (ok && stored != 0) begin
            check("data", data_o, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; valide = 1'b0; data_i = '0; ok = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      exp_q.delete();
      pending_push = 1'b0;
      mon_en = 1'b1;
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_data", data_o, 32'h0);

      // Three writes with no reads
      step(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
      check("three_count", 32'(count_o), 32'd3);
      check("three_head", data_o, 32'h11);
      check("three_valid", 32'(valid_o), 32'd1);

      // Fill, then offer a write together with a pop while full
      step(1'b1, 32'h44, 1'b0, 1'b0, 1'b1);
      check("full_ready", 32'(ready_o), 32'd0);
      step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
      check("full_pop_count", 32'(count_o), 32'd3);
      check("full_pop_head", data_o, 32'h22);

      // Flush with a simultaneous write
      step(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
      check("flush_count", 32'(count_o), 32'd0);
      check("flush_valid", 32'(valid_o), 32'd0);
      check("flush_data", data_o, 32'h0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Fall-through with ok held high
      step(1'b1, 32'hA5, 1'b1, 1'b0, 1'b1);
      check("ft_data", data_o, 32'hA5);
      check("ft_valid", 32'(valid_o), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("ft_empty", 32'(valid_o), 32'd0);

      // Stream 1..10 with ok toggling; scoreboard checks order across the wrap
      for (int i = 1; i <= 10; i++) begin
         while (ready_o !== 1'b1 && exp_q.size() == DEPTH)
            step(1'b0, '0, 1'b1, 1'b0, 1'b1);
         step(1'b1, DW'(i), logic'(i[0]), 1'b0, 1'b1);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("stream_drained", 32'(count_o), 32'd0);

      // Mid-operation reset with two entries stored
      step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hB3, 1'b1, 1'b0, 1'b0);
      check("mrst_count", 32'(count_o), 32'd0);
      check("mrst_ready", 32'(ready_o), 32'd1);
      check("mrst_valid", 32'(valid_o), 32'd0);
      step(1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
      check("mrst_head", data_o, 32'h5);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Randomised traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 3) != 0), $urandom(),
              logic'($urandom_range(0, 2) != 0),
              logic'($urandom_range(0, 31) == 0),
              logic'($urandom_range(0, 63) != 0));
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("final_count", 32'(count_o), 32'd0);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
